// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and optional write-to-read bypass.
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rdata,
  output logic [NUM_READ-1:0]             rbusy,
  input  logic [NUM_WRITE-1:0]            wen,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic                           alloc_en,
  input  logic [ADDR_WIDTH-1:0]           alloc_addr,
  output logic [(2**ADDR_WIDTH)-1:0]      busy_vec
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;

  // Index 0 is not a real destination when it is hardwired to zero.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return !ZR || (a != {ADDR_WIDTH{1'b0}});
  endfunction

  // Next-state for storage and scoreboard; ascending loop lets the highest write port win.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (wen[w] && addr_ok(waddr[w*ADDR_WIDTH +: ADDR_WIDTH])) begin
        mem_d[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]]  = wdata[w*DATA_WIDTH +: DATA_WIDTH];
        busy_d[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
    end
    // A newly issued producer supersedes one completing in the same cycle.
    if (alloc_en && addr_ok(alloc_addr)) begin
      busy_d[alloc_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (ZR) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  genvar gi;
  for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_s;
    logic [DATA_WIDTH-1:0] val_s;
    logic                  fwd_s;
    logic                  alloc_hit_s;

    assign ra_s        = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign alloc_hit_s = alloc_en && (alloc_addr == ra_s);

    // Read mux with optional forwarding; same port priority as the write path.
    always_comb begin
      val_s = mem_q[ra_s];
      fwd_s = 1'b0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (BP && wen[w] && (waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == ra_s) && addr_ok(ra_s)) begin
          val_s = wdata[w*DATA_WIDTH +: DATA_WIDTH];
          fwd_s = 1'b1;
        end else begin
          fwd_s = fwd_s;
        end
      end
    end

    assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
      (!rst_n || !addr_ok(ra_s)) ? {DATA_WIDTH{1'b0}} : val_s;
    assign rbusy[gi] = rst_n && busy_q[ra_s] && !(fwd_s && !alloc_hit_s);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp: one bypassing dual-write instance and one non-bypass instance.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [31:0] busy_vec;
  logic [63:0] rdata_nb;
  logic [1:0]  rbusy_nb;
  logic [31:0] busy_vec_nb;

  int total = 0;
  int bad   = 0;

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(2),
               .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(busy_vec)
  );

  regfile_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_READ(2), .NUM_WRITE(1),
               .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .wen(wen[0:0]), .waddr(waddr[4:0]), .wdata(wdata[31:0]), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(busy_vec_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        al;  logic [4:0] aa;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] e0;  logic [31:0] e1;
    logic [1:0]  erb; logic [31:0] ebv; logic [31:0] enb;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(
      input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
      input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
      input logic al,  input logic [4:0] aa,
      input logic [4:0] ra0, input logic [4:0] ra1,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic [1:0] erb, input logic [31:0] ebv, input logic [31:0] enb);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
    v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.al = al; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.erb = erb; v.ebv = ebv; v.enb = enb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    wen = 2'b00; waddr = 10'd0; wdata = 64'd0; alloc_en = 1'b0; alloc_addr = 5'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    raddr = {5'd0, 5'd5};

    // Reset state
    @(negedge clk); #2;
    chk("reset_rdata0", rdata[31:0], 32'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_rbusy", {30'd0, rbusy}, 32'h0);

    // Release reset, write x5 and allocate x6
    @(negedge clk);
    rst_n = 1'b1;
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'h0000_1234};
    alloc_en = 1'b1; alloc_addr = 5'd6;
    @(negedge clk);
    idle();
    #2;
    chk("pre_reset_x5", rdata[31:0], 32'h0000_1234);
    chk("pre_reset_busy", busy_vec, 32'h0000_0040);

    // Reset mid-operation: pending write/alloc discarded, outputs zero
    @(negedge clk);
    rst_n = 1'b0;
    wen = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'h0000_9999};
    alloc_en = 1'b1; alloc_addr = 5'd8;
    #2;
    chk("in_reset_rdata0", rdata[31:0], 32'h0);
    chk("in_reset_busy_vec", busy_vec, 32'h0);
    @(negedge clk); #2;
    chk("in_reset_hold_rdata0", rdata[31:0], 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #2;
    chk("post_reset_x5", rdata[31:0], 32'h0);
    chk("post_reset_nb_x5", rdata_nb[31:0], 32'h0);
    chk("post_reset_busy_vec", busy_vec, 32'h0);

    vecs[0]  = mk(1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3,  5'd0,
                  32'hDEAD_BEEF, 32'h0, 2'b00, 32'h0, 32'h0);
    vecs[1]  = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 32'h0, 32'hDEAD_BEEF);
    vecs[2]  = mk(1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd3, 5'd0,
                  32'hDEAD_BEEF, 32'h0, 2'b00, 32'h0, 32'hDEAD_BEEF);
    vecs[3]  = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 2'b00, 32'h0, 32'h0);
    vecs[4]  = mk(1'b1, 5'd7,  32'hA5A5_A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                  32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b00, 32'h0, 32'h0);
    vecs[5]  = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd7,
                  32'h0, 32'hA5A5_A5A5, 2'b00, 32'h0, 32'h0);
    vecs[6]  = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                  32'h0, 32'h0, 2'b11, 32'h0000_0200, 32'h0);
    vecs[7]  = mk(1'b1, 5'd9,  32'h0000_0055, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd3,
                  32'h0000_0055, 32'hDEAD_BEEF, 2'b00, 32'h0000_0200, 32'h0);
    vecs[8]  = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                  32'h0000_0055, 32'h0000_0055, 2'b00, 32'h0, 32'h0000_0055);
    vecs[9]  = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd4,
                  32'h0000_0055, 32'h0, 2'b00, 32'h0, 32'h0000_0055);
    vecs[10] = mk(1'b1, 5'd9,  32'h0000_0066, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9,
                  32'h0000_0066, 32'h0000_0066, 2'b11, 32'h0000_0200, 32'h0000_0055);
    vecs[11] = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9,
                  32'h0000_0066, 32'h0000_0066, 2'b11, 32'h0000_0200, 32'h0000_0066);
    vecs[12] = mk(1'b1, 5'd4,  32'h0000_0011, 1'b1, 5'd4, 32'h0000_0022, 1'b0, 5'd0, 5'd4, 5'd4,
                  32'h0000_0022, 32'h0000_0022, 2'b00, 32'h0000_0200, 32'h0);
    vecs[13] = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd9,
                  32'h0000_0022, 32'h0000_0066, 2'b10, 32'h0000_0200, 32'h0000_0011);
    vecs[14] = mk(1'b0, 5'd0,  32'h0, 1'b1, 5'd9, 32'h0000_0077, 1'b0, 5'd0, 5'd9, 5'd3,
                  32'h0000_0077, 32'hDEAD_BEEF, 2'b00, 32'h0000_0200, 32'h0000_0066);
    vecs[15] = mk(1'b1, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd1, 32'h1234_5678, 1'b1, 5'd1, 5'd31, 5'd1,
                  32'hCAFE_F00D, 32'h1234_5678, 2'b00, 32'h0, 32'h0);
    vecs[16] = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd1,
                  32'hCAFE_F00D, 32'h1234_5678, 2'b10, 32'h0000_0002, 32'hCAFE_F00D);
    vecs[17] = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 5'd1, 5'd0,
                  32'h1234_5678, 32'h0, 2'b01, 32'h0000_0002, 32'h0);
    vecs[18] = mk(1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd31,
                  32'h1234_5678, 32'hCAFE_F00D, 2'b01, 32'h0000_0002, 32'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      wen        = {vecs[i].we1, vecs[i].we0};
      waddr      = {vecs[i].wa1, vecs[i].wa0};
      wdata      = {vecs[i].wd1, vecs[i].wd0};
      alloc_en   = vecs[i].al;
      alloc_addr = vecs[i].aa;
      raddr      = {vecs[i].ra1, vecs[i].ra0};
      #2;
      chk($sformatf("v%0d_rdata0", i), rdata[31:0], vecs[i].e0);
      chk($sformatf("v%0d_rdata1", i), rdata[63:32], vecs[i].e1);
      chk($sformatf("v%0d_rbusy", i), {30'd0, rbusy}, {30'd0, vecs[i].erb});
      chk($sformatf("v%0d_busy_vec", i), busy_vec, vecs[i].ebv);
      chk($sformatf("v%0d_nobypass_rdata0", i), rdata_nb[31:0], vecs[i].enb);
    end

    @(negedge clk);
    idle();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
